// File: rtl/event_window_counter_if.sv
// AXI-Stream style record channel carrying {drop, sat, count} window records.
// COUNT_WIDTH must match the producing event_window_counter instance.
interface event_window_counter_if #(
   parameter int COUNT_WIDTH = 16
);
   logic [COUNT_WIDTH+1:0] tdata;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/event_window_counter.sv
// Counts rising edges of the sampled event level over programmable windows
// and emits one {drop, sat, count} record per window on a single-entry output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no window running; waits for enable to latch a window length
// ST_RUN  | window in progress; timer counts down to the last cycle (1)
module event_window_counter #(
   parameter int COUNT_WIDTH  = 16,
   parameter int WINDOW_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    event_in,
   input  logic                    enable,
   input  logic [WINDOW_WIDTH-1:0] window_len,
   event_window_counter_if.master  m_axis,
   output logic                    busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0]  COUNT_MAX = '1;
   localparam logic [WINDOW_WIDTH-1:0] TIMER_ONE = WINDOW_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [WINDOW_WIDTH-1:0] timer_q, timer_d;
   logic [WINDOW_WIDTH-1:0] len_latch;
   logic [COUNT_WIDTH-1:0]  count_q, count_d, count_inc;
   logic                    sat_q, sat_d, sat_inc;
   logic                    event_d;
   logic                    edge_det;
   logic                    drop_pending;
   logic                    rec_valid;
   logic                    rec_load;
   logic [COUNT_WIDTH+1:0]  rec_data;
   logic [COUNT_WIDTH+1:0]  tdata_q;
   logic                    tvalid_q;

   assign edge_det  = event_in & ~event_d;
   assign len_latch = (window_len == '0) ? TIMER_ONE : window_len;

   // Saturating count including the current cycle's edge
   always_comb begin
      count_inc = count_q;
      sat_inc   = sat_q;
      if (edge_det) begin
         if (count_q == COUNT_MAX) begin
            sat_inc = 1'b1;
         end else begin
            count_inc = count_q + COUNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      count_d   = count_q;
      sat_d     = sat_q;
      rec_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
               timer_d = len_latch;
               count_d = '0;
               sat_d   = 1'b0;
            end
         end
         ST_RUN: begin
            busy    = 1'b1;
            count_d = count_inc;
            sat_d   = sat_inc;
            timer_d = timer_q - TIMER_ONE;
            if (timer_q == TIMER_ONE) begin
               rec_valid = 1'b1;
               if (enable) begin
                  timer_d = len_latch;
                  count_d = '0;
                  sat_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rec_data = {drop_pending, sat_inc, count_inc};
   assign rec_load = rec_valid && (!tvalid_q || m_axis.tready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         count_q      <= '0;
         sat_q        <= 1'b0;
         event_d      <= 1'b0;
         drop_pending <= 1'b0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         event_d <= event_in;
         if (rec_load) begin
            tdata_q      <= rec_data;
            tvalid_q     <= 1'b1;
            drop_pending <= 1'b0;
         end else if (rec_valid) begin
            // Output full and stalled: lose this record, flag it on the next one
            drop_pending <= 1'b1;
         end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;

endmodule
